// File: rtl/ntt_stage_sequencer.sv
// Stage/index sequencer for the banked NTT/INTT/PWM datapath, with start/done handshake and inter-stage drain.
// Optional macro NTT_SEQ_STALL_EN adds a stall input that pauses READ.
module ntt_stage_sequencer #(
  parameter int unsigned LOG_N      = 8,
  parameter int unsigned BFU_NUM    = 4,
  parameter int unsigned STAGE_NUM  = 4,
  parameter int unsigned PIPE_DEPTH = 13,
  parameter int unsigned IDX_W      = LOG_N - $clog2(2 * BFU_NUM),
  parameter int unsigned STAGE_W    = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         conf,
`ifdef NTT_SEQ_STALL_EN
  input  logic               stall,
`endif
  output logic               busy,
  output logic [STAGE_W-1:0] stage,
  output logic [IDX_W-1:0]   idx,
  output logic               ren,
  output logic               wen,
  output logic               en,
  output logic               sel,
  output logic               done,
  output logic [3:0]         done_flag
);

  localparam int unsigned DRN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRN_W-1:0]   DRN_LAST   = DRN_W'(PIPE_DEPTH - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_NUM - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic                  ren_q, ren_d;
  logic                  sel_q, sel_d;
  logic [1:0]            mode_q, mode_d;
  logic [3:0]            flags_q, flags_d;
  logic [PIPE_DEPTH-1:0] wen_sr_q, wen_sr_d;
  logic                  stall_w;
  logic [STAGE_W-1:0]    last_stage;

`ifdef NTT_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      idx_q    <= '0;
      drn_q    <= '0;
      ren_q    <= 1'b0;
      sel_q    <= 1'b0;
      mode_q   <= '0;
      flags_q  <= '0;
      wen_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      idx_q    <= idx_d;
      drn_q    <= drn_d;
      ren_q    <= ren_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      flags_q  <= flags_d;
      wen_sr_q <= wen_sr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    idx_d       = idx_q;
    drn_d       = drn_q;
    ren_d       = 1'b0;
    sel_d       = sel_q;
    mode_d      = mode_q;
    flags_d     = flags_q;
    last_stage  = (mode_q == 2'd3) ? '0 : STAGE_LAST;
    wen_sr_d[0] = ren_q;
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) wen_sr_d[i] = wen_sr_q[i-1];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (conf == 3'd1 || conf == 3'd2 || conf == 3'd3) begin
            mode_d  = conf[1:0];
            sel_d   = (conf == 3'd2);
            flags_d = '0;
            stage_d = '0;
            idx_d   = '0;
            ren_d   = 1'b1;
            state_d = S_READ;
          end else begin
            flags_d = 4'b1000;
          end
        end
      end
      S_READ: begin
        // idx advances only after a read actually issued; a bubble cycle re-presents the pending idx
        if (ren_q && idx_q == IDX_LAST) begin
          idx_d   = '0;
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          if (ren_q) idx_d = idx_q + 1'b1;
          ren_d = ~stall_w;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          if (stage_q < last_stage) begin
            stage_d = stage_q + 1'b1;
            ren_d   = 1'b1;
            state_d = S_READ;
          end else begin
            case (mode_q)
              2'd1:    flags_d[0] = 1'b1;
              2'd2:    flags_d[1] = 1'b1;
              2'd3:    flags_d[2] = 1'b1;
              default: flags_d    = flags_q;
            endcase
            state_d = S_DONE;
          end
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      S_DONE: begin
        stage_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    stage     = stage_q;
    idx       = idx_q;
    ren       = ren_q;
    wen       = wen_sr_q[PIPE_DEPTH-1];
    en        = ren_q | wen_sr_q[PIPE_DEPTH-1];
    sel       = sel_q;
    done_flag = flags_q;
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer at default parameters (N=256, 4 BFUs, 4 stages, depth 13).
module tb_ntt_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] conf = 3'd0;
  logic       stall = 1'b0;
  logic       busy, ren, wen, en, sel, done;
  logic [1:0] stage;
  logic [4:0] idx;
  logic [3:0] done_flag;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_stage_sequencer #(.LOG_N(8), .BFU_NUM(4), .STAGE_NUM(4), .PIPE_DEPTH(13)) dut (
    .clk(clk), .rst(rst), .start(start), .conf(conf),
`ifdef NTT_SEQ_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .stage(stage), .idx(idx), .ren(ren), .wen(wen), .en(en),
    .sel(sel), .done(done), .done_flag(done_flag)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ren, wen, en, sel, done, stage, idx, done_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b ren=%b wen=%b en=%b sel=%b done=%b stage=%0d idx=%0d flag=%b want all 0",
               busy, ren, wen, en, sel, done, stage, idx, done_flag);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b ren=%b want 0 0", busy, ren);
    end
  endtask

  // Issue a one-cycle start and check every cycle of the run against the closed-form schedule.
  task automatic run_op(input logic [2:0] c, input int nst, input bit mid_start,
                        input logic [3:0] exp_flags, input string nm);
    int len = nst * 45 + 1;
    int p, s, pw, sw;
    logic e_ren, e_wen, e_done, e_busy;
    logic [4:0] e_idx;
    logic [1:0] e_stage;
    @(negedge clk);
    start = 1'b1;
    conf  = c;
    @(posedge clk);
    for (int cyc = 1; cyc <= len + 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; conf = 3'd1; end
      if (mid_start && cyc == 60) begin start = 1'b1; conf = 3'd2; end
      if (mid_start && cyc == 61) start = 1'b0;
      p = (cyc - 1) % 45;
      s = (cyc - 1) / 45;
      e_ren   = (s < nst) && (p < 32);
      e_idx   = e_ren ? 5'(p) : 5'd0;
      e_stage = (cyc < len) ? 2'(s) : ((cyc == len) ? 2'(nst - 1) : 2'd0);
      e_wen   = 1'b0;
      if (cyc >= 14) begin
        pw = (cyc - 14) % 45;
        sw = (cyc - 14) / 45;
        e_wen = (sw < nst) && (pw < 32);
      end
      e_done = (cyc == len);
      e_busy = (cyc <= len);
      checks++;
      if ({ren, wen, en, busy, done} !== {e_ren, e_wen, e_ren | e_wen, e_busy, e_done}) begin
        errors++;
        $display("FAIL %s_ctrl cyc=%0d got ren,wen,en,busy,done=%b%b%b%b%b want %b%b%b%b%b", nm, cyc,
                 ren, wen, en, busy, done, e_ren, e_wen, e_ren | e_wen, e_busy, e_done);
      end
      checks++;
      if (idx !== e_idx || stage !== e_stage) begin
        errors++;
        $display("FAIL %s_count cyc=%0d got stage=%0d idx=%0d want stage=%0d idx=%0d", nm, cyc,
                 stage, idx, e_stage, e_idx);
      end
      if (e_busy) begin
        checks++;
        if (sel !== (c == 3'd2)) begin
          errors++;
          $display("FAIL %s_sel cyc=%0d got %b want %b", nm, cyc, sel, (c == 3'd2));
        end
      end
    end
    checks++;
    if (done_flag !== exp_flags) begin
      errors++;
      $display("FAIL %s_flag got %b want %b", nm, done_flag, exp_flags);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    start = 1'b1;
    conf  = 3'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || ren !== 1'b0 || done_flag !== 4'b1000) begin
        errors++;
        $display("FAIL illegal_conf got busy=%b ren=%b flag=%b want 0 0 1000", busy, ren, done_flag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1;
    conf  = 3'd1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 70; cyc++) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ren, wen, busy, stage} !== {3'b111, 2'd1}) begin
      errors++;
      $display("FAIL areset_pre got ren=%b wen=%b busy=%b stage=%0d want 1 1 1 1", ren, wen, busy, stage);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ren, wen, en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL areset_drop got ren=%b wen=%b en=%b busy=%b done=%b want 0", ren, wen, en, busy, done);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || done_flag !== 4'b0000) begin
        errors++;
        $display("FAIL areset_hold got done=%b flag=%b want 0 0000", done, done_flag);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    conf  = 3'd3;
    @(posedge clk);
    for (int cyc = 1; cyc <= 48; cyc++) begin
      @(negedge clk);
      if (cyc == 46) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done got %b want 1", done);
        end
      end
      if (cyc == 47) begin
        checks++;
        if (busy !== 1'b0 || done_flag !== 4'b0100) begin
          errors++;
          $display("FAIL b2b_idle got busy=%b flag=%b want 0 0100", busy, done_flag);
        end
      end
      if (cyc == 48) begin
        checks++;
        if (busy !== 1'b1 || ren !== 1'b1 || done_flag !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_restart got busy=%b ren=%b flag=%b want 1 1 0000", busy, ren, done_flag);
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_finish got busy=%b want 0", busy);
    end
  endtask

`ifdef NTT_SEQ_STALL_EN
  task automatic test_stall();
    @(negedge clk);
    start = 1'b1;
    conf  = 3'd1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 188; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 100) stall = 1'b1;
      if (cyc == 105) stall = 1'b0;
      if (cyc >= 101 && cyc <= 105) begin
        checks++;
        if (ren !== 1'b0 || idx !== 5'd10 || stage !== 2'd2) begin
          errors++;
          $display("FAIL stall_bubble cyc=%0d got ren=%b idx=%0d stage=%0d want 0 10 2", cyc, ren, idx, stage);
        end
      end
      if (cyc == 106) begin
        checks++;
        if (ren !== 1'b1 || idx !== 5'd10) begin
          errors++;
          $display("FAIL stall_resume got ren=%b idx=%0d want 1 10", ren, idx);
        end
      end
      if (cyc >= 114 && cyc <= 118) begin
        checks++;
        if (wen !== 1'b0) begin
          errors++;
          $display("FAIL stall_wen cyc=%0d got %b want 0", cyc, wen);
        end
      end
      if (cyc == 185 || cyc == 186) begin
        checks++;
        if (done !== (cyc == 186)) begin
          errors++;
          $display("FAIL stall_done cyc=%0d got %b want %b", cyc, done, (cyc == 186));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    run_op(3'd1, 4, 1'b0, 4'b0001, "ntt");
    run_op(3'd2, 4, 1'b0, 4'b0010, "intt");
    run_op(3'd3, 1, 1'b0, 4'b0100, "pwm");
    test_illegal();
    run_op(3'd1, 4, 1'b1, 4'b0001, "overlap");
    test_async_reset();
    run_op(3'd1, 4, 1'b0, 4'b0001, "post_reset");
    test_back_to_back();
`ifdef NTT_SEQ_STALL_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
Parametrised control sequencer for the banked NTT / INTT / point-wise multiply datapath. It replaces the fixed-size controller and the fixed 13-cycle write-enable delay line. It generates the stage and index counters consumed by the address and twiddle generators, plus read enable, bank enable, butterfly mode select and pipeline-compensated write enable. It adds a start/busy/done handshake, drains the pipeline between stages to avoid read-after-write hazards, and reports sticky per-mode completion flags.

Parameters:
LOG_N, 8, log2 of polynomial length N (default N=256)
BFU_NUM, 4, butterflies per cycle; 2*BFU_NUM coefficients accessed per cycle (power of 2)
STAGE_NUM, 4, passes per NTT/INTT (radix-4, N=256 -> 4)
PIPE_DEPTH, 13, cycles from read issue to write-back of the same coefficients (>=1)
IDX_W, LOG_N-log2(2*BFU_NUM), derived; width of idx (default 5, i.e. 32 cycles per stage)
STAGE_W, clog2(STAGE_NUM), derived; width of stage (minimum 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  start request; sampled only in IDLE
conf  in  3  mode, sampled with start: 1=NTT, 2=INTT, 3=point-wise multiply (PWM); others are illegal
busy  out  1  high from the cycle after an accepted start until DONE, inclusive
stage  out  STAGE_W  current pass number
idx  out  IDX_W  read index within the current pass
ren  out  1  bank read enable
wen  out  1  bank write enable; ren delayed PIPE_DEPTH cycles
en  out  1  bank enable = ren | wen
sel  out  1  butterfly mode: 1 when the latched mode is INTT, else 0
done  out  1  single-cycle completion pulse
done_flag  out  4  sticky: [0] NTT done, [1] INTT done, [2] PWM done, [3] illegal conf

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; stage, idx, ren, wen, en, sel, busy, done and done_flag all 0; delay line cleared. wen drops immediately, even mid-operation.
- IDLE:
  - start=1 with legal conf: latch conf, clear done_flag, go to READ next cycle. stage=0, idx=0.
  - start=1 with illegal conf: stay in IDLE, set done_flag=4'b1000.
- READ: ren=1; idx increments each cycle.
  - At idx=2^IDX_W-1, go to DRAIN next cycle. idx wraps to 0.
- DRAIN: ren=0 for exactly PIPE_DEPTH cycles; a drain counter counts 0..PIPE_DEPTH-1.
  - At the end of the drain, if stage < last: stage+1 and back to READ.
  - Otherwise go to DONE.
  - Last stage is STAGE_NUM-1 for NTT/INTT and 0 for PWM (single pass).
- DONE: one cycle. done=1, busy=1, and the done_flag bit for the latched mode is set. Go to IDLE next cycle; stage returns to 0.
- Outputs stage, idx, ren and sel are registered.
- Write path: wen is a PIPE_DEPTH-stage shift register fed by ren. The last write of a pass coincides with the final DRAIN cycle, so the next pass's first read is one cycle after the last write.
- Latency:
  - NTT/INTT: done asserts STAGE_NUM*(2^IDX_W+PIPE_DEPTH)+1 cycles after the start edge.
  - PWM: done asserts 2^IDX_W+PIPE_DEPTH+1 cycles after the start edge.
- Edge cases:
  - start while busy: ignored; no state change, flags unchanged.
  - start held high: a new run starts only on an IDLE cycle, i.e. the cycle after DONE.
  - conf changes during a run: ignored; the latched value is used.
  - Reset mid-operation: returns to IDLE; no done pulse; done_flag cleared.

Optional Feature:
Macro NTT_SEQ_STALL_EN.
- Defined: adds input port stall (1 bit). While stall=1 in READ:
  - ren=0, and idx and state hold.
  - The wen delay line keeps shifting, so write bubbles mirror read bubbles.
  - stall has no effect in IDLE, DRAIN or DONE.
  - Latency grows by exactly the number of stalled READ cycles.
- Undefined: no stall port; READ never pauses.

Test Plan:
- Reset then NTT, defaults: rst low 3 cycles, start=1 conf=1 for 1 cycle -> ren high for 4 blocks of 32 cycles separated by 13-cycle gaps; wen is ren delayed 13; done pulse at cycle 181; done_flag=4'b0001; sel=0 throughout.
- INTT: start conf=2 -> sel=1 during busy; done at cycle 181; done_flag=4'b0010 (NTT bit cleared by the new start).
- PWM: start conf=3 -> a single 32-cycle ren burst with stage=0; done at cycle 46; done_flag=4'b0100.
- Illegal and overlapping start: conf=5 -> busy stays 0, done_flag=4'b1000. Start pulse during a running NTT -> ignored; done still at 181.
- Async reset mid-run: assert rst=0 at cycle 70 (stage 1) -> wen, ren and busy drop before the next clock edge; no done pulse; a fresh start afterwards completes normally at 181.
- NTT_SEQ_STALL_EN defined: stall=1 for 5 cycles during stage 2 READ -> idx held, 5-cycle ren and wen bubbles; done at cycle 186. Parameter sweep LOG_N=10, BFU_NUM=2, STAGE_NUM=5, PIPE_DEPTH=7 -> 5*(256+7)+1=1316-cycle latency.
